hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous active-high reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegWrite  input  1  instruction in EX writes the register file
- ID_EX_WriteReg  input  5  destination register of the instruction in EX
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_WriteReg  input  5  destination register of the instruction in MEM
- IF_ID_RegisterRs  input  5  Rs of the instruction in ID
- IF_ID_RegisterRt  input  5  Rt of the instruction in ID
- IF_ID_UsesRt  input  1  instruction in ID reads Rt as a source
- ID_Branch  input  1  instruction in ID is a beq/bne resolved in ID
- Branch_Taken  input  1  ID comparison result is taken
- Jump  input  1  instruction in ID is j/jal/jr
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register load enable
- ID_EX_Bubble  output  1  zeroes the ID/EX control fields
- IF_ID_Flush  output  1  clears IF/ID to a nop
- Stall_Cause  output  2  registered cause code: 00 none, 01 load-use, 10 branch-ALU, 11 branch-load

Function
REQ-003 A register match SHALL require equal 5-bit numbers and a nonzero register; register 0 never matches.
REQ-004 A load-use hazard SHALL exist when ID_EX_MemRead=1 and ID_EX_WriteReg matches IF_ID_RegisterRs, or matches IF_ID_RegisterRt while IF_ID_UsesRt=1; the required stall count is 1.
REQ-005 A branch-ALU hazard SHALL exist when ID_Branch=1, ID_EX_RegWrite=1, ID_EX_MemRead=0, and ID_EX_WriteReg matches Rs or Rt; the required stall count is 1.
REQ-006 A branch-load hazard SHALL exist when ID_Branch=1, ID_EX_MemRead=1, and ID_EX_WriteReg matches Rs or Rt (stall count 2), or when EX_MEM_MemRead=1 and EX_MEM_WriteReg matches Rs or Rt (stall count 1).
REQ-007 When several hazards hold, the required stall count SHALL be the maximum; Stall_Cause SHALL take the code of the hazard giving that maximum, with branch-load taking priority over branch-ALU, and branch-ALU over load-use.
REQ-008 The FSM SHALL have the states RUN and STALL, with a 2-bit counter cnt.
REQ-009 In RUN with a required stall count N>0, the block SHALL in the same cycle drive PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 and IF_ID_Flush=0.
REQ-010 In the case of REQ-009, the block SHALL then load cnt=N-1 and go to STALL if N=2, or remain in RUN if N=1.
REQ-011 In STALL, the block SHALL hold PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, ignore new hazard detection, and decrement cnt.
REQ-012 In STALL, the block SHALL return to RUN on the clock edge at which cnt=0.
REQ-013 In RUN with no hazard, the block SHALL drive PCWrite=1, IF_ID_Write=1 and ID_EX_Bubble=0.
REQ-014 In the case of REQ-013, IF_ID_Flush SHALL equal (ID_Branch & Branch_Taken) | Jump.
REQ-015 A hazard SHALL suppress IF_ID_Flush; the branch is evaluated again after the stall.
REQ-016 Stall_Cause SHALL be registered on the edge at which a stall begins, held through STALL, and cleared to 00 on the first RUN cycle without a hazard.
REQ-017 Outputs SHALL depend only on the current state and the current inputs, with zero added latency; there are no hidden pipeline stages.

Reset
REQ-018 While reset=1 at a rising edge of clk, the block SHALL go to state RUN, set cnt=0 and set Stall_Cause=00.
REQ-019 The reset of REQ-018 SHALL apply even in the middle of a stall.
REQ-020 Outputs during and after reset SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0 and IF_ID_Flush=0, unless the inputs present a hazard or a flush condition.
REQ-021 If the config feature is enabled, reset SHALL also clear the counters.

Configuration
REQ-022 The macro HAZARD_PERF_CNT_EN SHALL select whether the performance counters are compiled in.
REQ-023 When HAZARD_PERF_CNT_EN is defined, the block SHALL add these outputs:
- Stall_Cycles, 32 bits: increments every cycle ID_EX_Bubble=1
- Flush_Count, 32 bits: increments every cycle IF_ID_Flush=1
REQ-024 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 When HAZARD_PERF_CNT_EN is undefined, neither port SHALL exist and no counter logic SHALL be present.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- lw $8 in EX, ID reads Rs=8 -> exactly 1 cycle of PCWrite=0/ID_EX_Bubble=1; Stall_Cause=01; then normal operation.
- beq in ID, Rs=9, with lw $9 in EX -> 2 consecutive stall cycles; Stall_Cause=11; IF_ID_Flush=0 throughout; flush asserted after the stall if Branch_Taken=1.
- beq in ID, Rt=10, UsesRt=1, with add $10 in EX -> 1 stall cycle; Stall_Cause=10.
- lw $0 in EX, ID Rs=0 -> no stall; Jump=1 -> IF_ID_Flush=1 for 1 cycle.
- reset=1 in the first STALL cycle of a branch-load stall -> next cycle state RUN, PCWrite=1, Stall_Cause=00.
- HAZARD_PERF_CNT_EN defined: 3 stall cycles and 2 flushes -> Stall_Cycles=3 and Flush_Count=2; a counter preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard unit: stalls IF/ID for load-use and branch-in-ID hazards, flushes IF/ID on taken branch or jump.
// Optional build macro HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
module hazard_detection_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_RegWrite,
    input  logic [4:0] ID_EX_WriteReg,
    input  logic       EX_MEM_MemRead,
    input  logic [4:0] EX_MEM_WriteReg,
    input  logic [4:0] IF_ID_RegisterRs,
    input  logic [4:0] IF_ID_RegisterRt,
    input  logic       IF_ID_UsesRt,
    input  logic       ID_Branch,
    input  logic       Branch_Taken,
    input  logic       Jump,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       IF_ID_Flush,
    output logic [1:0] Stall_Cause
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Cycles,
    output logic [31:0] Flush_Count
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_LOAD   = 2'b01;
    localparam logic [1:0] CAUSE_BR_ALU = 2'b10;
    localparam logic [1:0] CAUSE_BR_LD  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] stall_cause_q, stall_cause_d;

    logic       load_use, branch_alu, branch_load_ex, branch_load_mem;
    logic       ex_hits, mem_hits, in_run;
    logic [1:0] need_cnt, need_cause;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    always_comb begin
        ex_hits  = reg_match(ID_EX_WriteReg, IF_ID_RegisterRs) | reg_match(ID_EX_WriteReg, IF_ID_RegisterRt);
        mem_hits = reg_match(EX_MEM_WriteReg, IF_ID_RegisterRs) | reg_match(EX_MEM_WriteReg, IF_ID_RegisterRt);
        load_use = ID_EX_MemRead & (reg_match(ID_EX_WriteReg, IF_ID_RegisterRs)
                 | (IF_ID_UsesRt & reg_match(ID_EX_WriteReg, IF_ID_RegisterRt)));
        branch_alu      = ID_Branch & ID_EX_RegWrite & ~ID_EX_MemRead & ex_hits;
        branch_load_ex  = ID_Branch & ID_EX_MemRead & ex_hits;
        branch_load_mem = ID_Branch & EX_MEM_MemRead & mem_hits;

        // Longest stall wins; among equal counts branch-load beats branch-ALU beats load-use.
        need_cnt   = 2'd0;
        need_cause = CAUSE_NONE;
        if (branch_load_ex) begin
            need_cnt   = 2'd2;
            need_cause = CAUSE_BR_LD;
        end else if (branch_load_mem) begin
            need_cnt   = 2'd1;
            need_cause = CAUSE_BR_LD;
        end else if (branch_alu) begin
            need_cnt   = 2'd1;
            need_cause = CAUSE_BR_ALU;
        end else if (load_use) begin
            need_cnt   = 2'd1;
            need_cause = CAUSE_LOAD;
        end
    end

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        IF_ID_Flush   = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_cause_d = stall_cause_q;
        // Reset forces RUN behaviour on the outputs even if the register still says STALL.
        in_run        = (state_q == RUN) || reset;

        if (in_run) begin
            if (need_cnt != 2'd0) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Bubble  = 1'b1;
                stall_cause_d = need_cause;
                cnt_d         = need_cnt - 2'd1;
                state_d       = (need_cnt == 2'd2) ? STALL : RUN;
            end else begin
                IF_ID_Flush   = (ID_Branch & Branch_Taken) | Jump;
                stall_cause_d = CAUSE_NONE;
                cnt_d         = 2'd0;
                state_d       = RUN;
            end
        end else begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            cnt_d        = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
            state_d      = (cnt_q <= 2'd1) ? RUN : STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 2'd0;
            stall_cause_q <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_cause_q <= stall_cause_d;
        end
    end

    assign Stall_Cause = stall_cause_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Free-running, wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ID_EX_Bubble};
        flush_count_d  = flush_count_q + {31'd0, IF_ID_Flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign Stall_Cycles = stall_cycles_q;
    assign Flush_Count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed vectors for hazard_detection_unit; expected outputs are queued per cycle and checked by a monitor.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
    logic [4:0] ID_EX_WriteReg, EX_MEM_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic       IF_ID_UsesRt, ID_Branch, Branch_Taken, Jump;
    logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic [1:0] Stall_Cause;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cycles, Flush_Count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    hazard_detection_unit dut (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_WriteReg(ID_EX_WriteReg),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_UsesRt(IF_ID_UsesRt), .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken), .Jump(Jump),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .Stall_Cause(Stall_Cause)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
`endif
    );

    always #5 clk = ~clk;

    // Expected word layout: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stall_Cause}
    task automatic drive(input logic rst, input logic idmr, input logic idrw, input logic [4:0] idwr,
                         input logic exmr, input logic [4:0] exwr, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic br, input logic tk, input logic jp);
        reset = rst; ID_EX_MemRead = idmr; ID_EX_RegWrite = idrw; ID_EX_WriteReg = idwr;
        EX_MEM_MemRead = exmr; EX_MEM_WriteReg = exwr; IF_ID_RegisterRs = rs; IF_ID_RegisterRt = rt;
        IF_ID_UsesRt = urt; ID_Branch = br; Branch_Taken = tk; Jump = jp;
    endtask

    task automatic step(input string nm, input logic rst, input logic idmr, input logic idrw, input logic [4:0] idwr,
                        input logic exmr, input logic [4:0] exwr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic br, input logic tk, input logic jp, input logic [5:0] expv);
        @(posedge clk);
        #1;
        drive(rst, idmr, idrw, idwr, exmr, exwr, rs, rt, urt, br, tk, jp);
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [5:0] expv);
        step(nm, 1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, expv);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        logic [5:0] e, a;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stall_Cause};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got pcw/ifw/bub/flush/cause=%b, expected %b", nm, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        step("reset_idle", 1'b1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b110000);
        idle("run_idle", 6'b110000);

        // lw $8 in EX, ID reads Rs=8
        step("lu_stall", 1'b0, 1, 1, 5'd8, 0, 5'd0, 5'd8, 5'd2, 0, 0, 0, 0, 6'b001000);
        step("lu_after", 1'b0, 0, 0, 5'd0, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0, 0, 6'b110001);
        idle("lu_clear", 6'b110000);

        // beq Rs=9 with lw $9 in EX, taken
        step("bl_stall1", 1'b0, 1, 1, 5'd9, 0, 5'd0, 5'd9, 5'd3, 1, 1, 1, 0, 6'b001000);
        step("bl_stall2", 1'b0, 0, 0, 5'd0, 1, 5'd9, 5'd9, 5'd3, 1, 1, 1, 0, 6'b001011);
        step("bl_flush",  1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd9, 5'd3, 1, 1, 1, 0, 6'b110111);
        idle("bl_clear", 6'b110000);

        // beq Rt=10 with add $10 in EX, not taken
        step("ba_stall", 1'b0, 0, 1, 5'd10, 0, 5'd0, 5'd4, 5'd10, 1, 1, 0, 0, 6'b001000);
        step("ba_after", 1'b0, 0, 0, 5'd0, 0, 5'd10, 5'd4, 5'd10, 1, 1, 0, 0, 6'b110010);
        idle("ba_clear", 6'b110000);

        // register 0 never matches; jump flushes for one cycle
        step("r0_nostall", 1'b0, 1, 1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 6'b110000);
        step("jump_flush", 1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 6'b110100);
        idle("jump_done", 6'b110000);

        // Rt only counts for load-use when UsesRt
        step("rt_unused", 1'b0, 1, 1, 5'd5, 0, 5'd0, 5'd1, 5'd5, 0, 0, 0, 0, 6'b110000);
        step("rt_used",   1'b0, 1, 1, 5'd5, 0, 5'd0, 5'd1, 5'd5, 1, 0, 0, 0, 6'b001000);
        idle("rt_after", 6'b110001);
        idle("rt_clear", 6'b110000);

        // branch-ALU and branch-load (MEM) both need 1: branch-load code wins
        step("tie_stall", 1'b0, 0, 1, 5'd6, 1, 5'd7, 5'd7, 5'd6, 1, 1, 0, 0, 6'b001000);
        idle("tie_cause", 6'b110011);
        idle("tie_clear", 6'b110000);

        // hazard suppresses jump flush
        step("jmp_haz",  1'b0, 1, 1, 5'd3, 0, 5'd0, 5'd3, 5'd0, 0, 0, 0, 1, 6'b001000);
        step("jmp_retry", 1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd3, 5'd0, 0, 0, 0, 1, 6'b110101);
        idle("jmp_clear", 6'b110000);

        // reset in the first STALL cycle of a branch-load stall
        step("rst_bl_enter", 1'b0, 1, 1, 5'd9, 0, 5'd0, 5'd9, 5'd0, 0, 1, 1, 0, 6'b001000);
        step("rst_in_stall", 1'b1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b110011);
        idle("rst_after", 6'b110000);

        // reset beats capturing a stall cause
        step("rst_with_haz", 1'b1, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 0, 0, 0, 0, 6'b001000);
        idle("rst_haz_after", 6'b110000);
        idle("tail", 6'b110000);

        repeat (2) @(posedge clk);

`ifdef HAZARD_PERF_CNT_EN
        drive(1'b1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1'b0, 1, 1, 5'd8, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0);   // 1 bubble
        @(posedge clk); #1;
        drive(1'b0, 1, 1, 5'd9, 0, 5'd0, 5'd9, 5'd0, 0, 1, 0, 0);   // 2 bubbles
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);   // flush
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);   // flush
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (Stall_Cycles === 32'd3) n_pass++;
        else $display("FAIL stall_cycles: got %0d, expected 3", Stall_Cycles);
        n_checks++;
        if (Flush_Count === 32'd2) n_pass++;
        else $display("FAIL flush_count: got %0d, expected 2", Flush_Count);

        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        drive(1'b0, 1, 1, 5'd8, 0, 5'd0, 5'd8, 5'd0, 0, 1, 0, 0);   // 2 bubbles: FFFFFFFE -> 0
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (Stall_Cycles === 32'd0) n_pass++;
        else $display("FAIL stall_wrap: got %h, expected 00000000", Stall_Cycles);
`endif

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
